mem_trans_ctrl: RTL
===================

Name: mem_trans_ctrl

Overview:
Transaction engine of the memory checker and the consumer of the address generator.
- Takes the current address from the generator and issues Avalon-MM write/read commands at it.
- Pulses next_addr_en_o to advance the generator.
- Checks read data against the test pattern and reports busy, done and the first mismatch to the CSR block.

Parameters:
ADDR_W, 16, Avalon word address width; the shared package constant is the source of truth.
DATA_W, 32, Avalon data width.
RD_PEND_MAX, 8, maximum outstanding reads; power of two, at least 2.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
test_start_i  in  1  one-cycle start pulse, shared with the address generator
test_mode_i  in  2  0 = WR_ONLY, 1 = RD_ONLY, 2 = WR_RD; 3 is reserved and treated as WR_ONLY
trans_amount_i  in  32  number of addresses to visit
data_pattern_i  in  DATA_W  write data and expected read data
next_addr_i  in  ADDR_W  current address from the generator
next_addr_en_o  out  1  advance-address pulse to the generator
amm_address_o  out  ADDR_W  Avalon address
amm_write_o  out  1  Avalon write request
amm_writedata_o  out  DATA_W  Avalon write data
amm_read_o  out  1  Avalon read request
amm_waitrequest_i  in  1  Avalon waitrequest
amm_readdatavalid_i  in  1  Avalon read-data valid
amm_readdata_i  in  DATA_W  Avalon read data
busy_o  out  1  test in progress
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky mismatch flag
err_addr_o  out  ADDR_W  address of the first mismatch
err_data_o  out  DATA_W  read data of the first mismatch

Behaviour:
- Reset: rst_i is asynchronous, active-high; clock is clk_i.
  - All outputs are 0, the FSM is in IDLE, and the pending FIFO and counters are cleared.
  - Reset mid-test aborts the test immediately; no done_o pulse is generated.
- FSM states: IDLE, START, WR, RD, DRAIN, DONE.
- IDLE:
  - test_start_i latches test_mode_i, trans_amount_i and data_pattern_i, clears err_o, err_addr_o and err_data_o, and moves to START.
  - test_start_i outside IDLE is ignored.
- START (one cycle): lets the generator load its start address.
  - trans_amount of 0 goes to DONE.
  - Otherwise the next state is RD for RD_ONLY and WR for all other modes.
- Command outputs:
  - amm_address_o = next_addr_i.
  - amm_writedata_o = latched pattern.
  - amm_write_o = (state == WR).
  - amm_read_o = (state == RD) && (pending < RD_PEND_MAX).
  - A command is accepted in a cycle where it is asserted and amm_waitrequest_i = 0.
- Address stability: while waitrequest holds a command, next_addr_en_o stays low, so the address is stable.
- Address advance: next_addr_en_o is asserted, combinationally, for exactly the accept cycle of the last command for an address.
  - WR_ONLY: the write accept.
  - RD_ONLY: the read accept.
  - WR_RD: the read accept; the write accept moves WR to RD at the same address without pulsing.
- Address counter: increments on each next_addr_en_o.
  - When the counter reaches trans_amount, go to DRAIN.
  - Otherwise WR_ONLY and WR_RD go to WR; RD_ONLY stays in RD.
- Pending FIFO (RD_PEND_MAX deep):
  - Each read accept pushes amm_address_o.
  - Each amm_readdatavalid_i pops one entry.
  - Push and pop in the same cycle keep the count unchanged.
  - readdatavalid with an empty FIFO is ignored and is a bench assertion failure.
- Check: on readdatavalid, if readdata differs from the pattern and err_o = 0:
  - set err_o and capture the popped address and the readdata;
  - later mismatches do not overwrite the capture.
- DRAIN: waits until pending = 0, then goes to DONE.
- DONE (one cycle): done_o = 1, then IDLE.
- busy_o = 1 in every state except IDLE.
  - Latency from start to the first command: 2 cycles (test_start_i, START, then command).

Decomposition:
- Shared package additions:
  - test_mode_t enum: WR_ONLY, RD_ONLY, WR_RD.
  - The CSR_TEST_PARAM bit positions for test_mode and the CSR_TRANS_AMOUNT index.
  - The done/err status bit indices.
- One sub-module, pend_addr_fifo: synchronous FIFO with show-ahead, ADDR_W wide, RD_PEND_MAX deep.
  - Ports: push, pop, full, empty, count.

Test Plan:
- WR_ONLY, trans_amount = 4, incrementing addresses from 0x0010, waitrequest = 0:
  - writes at 0x10..0x13 on 4 consecutive cycles;
  - 4 next_addr_en_o pulses;
  - done_o two cycles after the last write accept, because DRAIN and DONE each take one cycle.
- WR_RD, trans_amount = 3, pattern 0xA5A5A5A5, memory model returns the stored data:
  - W/R/W/R/W/R sequence to the same address pairs;
  - next_addr_en_o only on read accepts;
  - err_o = 0 and done_o = 1.
- RD_ONLY, memory corrupts 0x0012 to 0xA5A5A5A4, then 0x0013 also corrupt:
  - err_o = 1, err_addr_o = 0x0012, err_data_o = 0xA5A5A5A4;
  - capture unchanged by 0x0013.
- Read latency 20 cycles, trans_amount = 16:
  - amm_read_o drops while 8 reads are pending and resumes after each return;
  - done_o only after the 16th readdatavalid.
- Random waitrequest at 50%:
  - address and command stable while held;
  - exactly trans_amount next_addr_en_o pulses.
- Boundary cases:
  - trans_amount = 0: no commands, done_o 2 cycles after start.
  - test_start_i while busy: ignored.
  - rst_i mid-DRAIN: outputs 0 at once and no done_o; a new test afterwards runs clean.

Source files
------------

// File: rtl/mem_trans_ctrl_pkg.sv
// Shared definitions for the memory checker: test modes, FSM states and the
// CSR field positions that the control block decodes.
package mem_trans_ctrl_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 32;
  localparam int RD_PEND_MAX = 8;

  typedef enum logic [1:0] {
    WR_ONLY = 2'd0,
    RD_ONLY = 2'd1,
    WR_RD   = 2'd2
  } test_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WR    = 3'd2,
    ST_RD    = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // CSR register indices and bit positions
  localparam int CSR_TEST_PARAM       = 0;
  localparam int CSR_TEST_MODE_LSB    = 0;
  localparam int CSR_TEST_MODE_MSB    = 1;
  localparam int CSR_TRANS_AMOUNT     = 1;
  localparam int CSR_STATUS_DONE_BIT  = 0;
  localparam int CSR_STATUS_ERR_BIT   = 1;

  // Reserved encoding 3 behaves as a plain write test.
  function automatic test_mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return RD_ONLY;
      2'd2:    return WR_RD;
      default: return WR_ONLY;
    endcase
  endfunction

endpackage

// File: rtl/mem_trans_ctrl_pend_addr_fifo.sv
// Show-ahead FIFO holding the addresses of reads still waiting for data;
// head_o is the address the next returning word belongs to.
module mem_trans_ctrl_pend_addr_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mem_trans_ctrl.sv
// Transaction engine: walks the generator's addresses issuing Avalon-MM
// writes/reads, checks returned data against the pattern, reports status.
module mem_trans_ctrl #(
  parameter int ADDR_W      = mem_trans_ctrl_pkg::ADDR_W,
  parameter int DATA_W      = mem_trans_ctrl_pkg::DATA_W,
  parameter int RD_PEND_MAX = mem_trans_ctrl_pkg::RD_PEND_MAX
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_start_i,
  input  logic [1:0]        test_mode_i,
  input  logic [31:0]       trans_amount_i,
  input  logic [DATA_W-1:0] data_pattern_i,
  input  logic [ADDR_W-1:0] next_addr_i,
  output logic              next_addr_en_o,
  output logic [ADDR_W-1:0] amm_address_o,
  output logic              amm_write_o,
  output logic [DATA_W-1:0] amm_writedata_o,
  output logic              amm_read_o,
  input  logic              amm_waitrequest_i,
  input  logic              amm_readdatavalid_i,
  input  logic [DATA_W-1:0] amm_readdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [DATA_W-1:0] err_data_o,
  output logic [2:0]        dbg_state_o
);
  import mem_trans_ctrl_pkg::*;

  localparam int CW = $clog2(RD_PEND_MAX) + 1;

  state_t            state_q, state_d;
  test_mode_t        mode_q;
  logic [31:0]       amount_q, addr_cnt_q;
  logic [DATA_W-1:0] pattern_q;
  logic              err_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [DATA_W-1:0] err_data_q;

  logic              start_ok, wr_acc, rd_acc, last_addr;
  logic              pend_full, pend_empty, pend_pop;
  logic [CW-1:0]     pend_count;
  logic [ADDR_W-1:0] pend_head;

  // Avalon handshake: a command is taken in any cycle where it is asserted
  // with waitrequest low; while waitrequest is high, command and address hold.
  assign wr_acc    = amm_write_o && !amm_waitrequest_i;
  assign rd_acc    = amm_read_o && !amm_waitrequest_i;
  assign start_ok  = (state_q == ST_IDLE) && test_start_i;
  assign last_addr = (addr_cnt_q + 32'd1 == amount_q);
  assign pend_pop  = amm_readdatavalid_i && !pend_empty;

  mem_trans_ctrl_pend_addr_fifo #(
    .W     (ADDR_W),
    .DEPTH (RD_PEND_MAX)
  ) u_pend_addr_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (rd_acc),
    .push_data_i (amm_address_o),
    .pop_i       (pend_pop),
    .head_o      (pend_head),
    .full_o      (pend_full),
    .empty_o     (pend_empty),
    .count_o     (pend_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q     <= WR_ONLY;
      amount_q   <= '0;
      pattern_q  <= '0;
      addr_cnt_q <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_data_q <= '0;
    end else if (start_ok) begin
      mode_q     <= decode_mode(test_mode_i);
      amount_q   <= trans_amount_i;
      pattern_q  <= data_pattern_i;
      addr_cnt_q <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_data_q <= '0;
    end else begin
      if (next_addr_en_o) addr_cnt_q <= addr_cnt_q + 32'd1;
      // Only the first mismatch of a test is captured.
      if (pend_pop && !err_q && (amm_readdata_i != pattern_q)) begin
        err_q      <= 1'b1;
        err_addr_q <= pend_head;
        err_data_q <= amm_readdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (test_start_i) state_d = ST_START;
      ST_START: begin
        if (amount_q == '0)          state_d = ST_DONE;
        else if (mode_q == RD_ONLY)  state_d = ST_RD;
        else                         state_d = ST_WR;
      end
      ST_WR: begin
        if (wr_acc) begin
          if (mode_q == WR_RD)  state_d = ST_RD;
          else if (last_addr)   state_d = ST_DRAIN;
          else                  state_d = ST_WR;
        end
      end
      ST_RD: begin
        if (rd_acc) begin
          if (last_addr)              state_d = ST_DRAIN;
          else if (mode_q == RD_ONLY) state_d = ST_RD;
          else                        state_d = ST_WR;
        end
      end
      ST_DRAIN: if (pend_count == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o         = (state_q != ST_IDLE);
    done_o         = (state_q == ST_DONE);
    amm_write_o    = (state_q == ST_WR);
    amm_read_o     = (state_q == ST_RD) && !pend_full;
    amm_address_o  = busy_o ? next_addr_i : '0;
    // Advance only on the final command of an address; in WR_RD that is the read.
    next_addr_en_o = 1'b0;
    if (!amm_waitrequest_i) begin
      if (mode_q == WR_ONLY) next_addr_en_o = amm_write_o;
      else                   next_addr_en_o = amm_read_o;
    end
  end

  assign amm_writedata_o = pattern_q;
  assign err_o           = err_q;
  assign err_addr_o      = err_addr_q;
  assign err_data_o      = err_data_q;
  assign dbg_state_o     = state_q;

endmodule
